// File: rtl/adc_sched_pkg.sv
// Shared state encoding and parameter defaults for the ADC sample scheduler.
// Pure declarations: no timing, no handshakes.
package adc_sched_pkg;

  localparam int CONVST_LOW_CYCLES_DEF = 2;
  localparam int BUSY_TIMEOUT_DEF      = 64;
  localparam int MIN_PERIOD_DEF        = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVST,
    S_WAIT_BUSY_HI,
    S_WAIT_BUSY_LO,
    S_READ,
    S_WAIT_DONE
  } sched_state_e;

  function automatic logic [15:0] clamp_period(input logic [15:0] period,
                                               input logic [15:0] min_period);
    return (period < min_period) ? min_period : period;
  endfunction

endpackage

// File: rtl/period_timer.sv
// Free-running sample period counter; one-cycle tick on the last count of each period.
// Period is re-latched only at wrap (or while disabled), so mid-period changes wait a full period.
module period_timer
  import adc_sched_pkg::*;
#(
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [15:0] i_period,
  output logic        o_tick
);

  localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);

  logic [15:0] r_count;
  logic [15:0] r_period;
  logic [15:0] w_period_clamped;
  logic        w_wrap;

  assign w_period_clamped = clamp_period(i_period, MIN_P);
  assign w_wrap           = (r_count == (r_period - 16'd1));
  assign o_tick           = i_enable & w_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_period <= MIN_P;
    end else if (!i_enable || w_wrap) begin
      r_count  <= '0;
      r_period <= w_period_clamped;
    end else begin
      r_count  <= r_count + 16'd1;
    end
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Paces ADC conversions: convst pulse, Busy handshake, readout request, sample accounting.
// Outputs decode straight from state; a conversion blocks new ticks (dropped, flagged as overrun).
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int CONVST_LOW_CYCLES = CONVST_LOW_CYCLES_DEF,
  parameter int BUSY_TIMEOUT      = BUSY_TIMEOUT_DEF,
  parameter int MIN_PERIOD        = MIN_PERIOD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] sample_period,
  input  logic [15:0] burst_len,
  input  logic        Busy,
  input  logic        rd_done,
  output logic        convst_n,
  output logic        rd_start,
  output logic        sample_valid,
  output logic        overrun,
  output logic        timeout_err,
  output logic        burst_done,
  output logic [31:0] sample_count
);

  localparam int               CYC_W       = 16;
  localparam logic [CYC_W-1:0] CONVST_LAST = CYC_W'(CONVST_LOW_CYCLES - 1);
  localparam logic [CYC_W-1:0] BUSY_LAST   = CYC_W'(BUSY_TIMEOUT - 1);

  sched_state_e     r_state;
  sched_state_e     w_next_state;
  logic [CYC_W-1:0] r_cyc;
  logic             r_enable_d;
  logic             r_overrun;
  logic             r_timeout_err;
  logic             r_burst_done;
  logic [31:0]      r_sample_count;
  logic [31:0]      w_count_inc;
  logic             w_tick;
  logic             w_en_rise;
  logic             w_tick_acc;
  logic             w_done_accept;
  logic             w_timeout_fire;
  logic             w_busy_limit;

  period_timer #(
    .MIN_PERIOD(MIN_PERIOD)
  ) u_period_timer (
    .clk      (clk),
    .rst      (rst),
    .i_enable (enable),
    .i_period (sample_period),
    .o_tick   (w_tick)
  );

  assign w_en_rise     = enable & ~r_enable_d;
  // The enable-rise clear wins over a coincident tick.
  assign w_tick_acc    = w_tick & ~w_en_rise;
  assign w_busy_limit  = (r_cyc == BUSY_LAST);
  assign w_done_accept = (r_state == S_WAIT_DONE) & rd_done;
  assign w_count_inc   = r_sample_count + 32'd1;

  always_comb begin
    w_next_state   = r_state;
    w_timeout_fire = 1'b0;
    convst_n       = 1'b1;
    rd_start       = 1'b0;
    sample_valid   = w_done_accept;
    case (r_state)
      S_IDLE: begin
        if (w_tick_acc && !r_burst_done) w_next_state = S_CONVST;
      end
      S_CONVST: begin
        convst_n = 1'b0;
        if (r_cyc == CONVST_LAST) w_next_state = S_WAIT_BUSY_HI;
      end
      S_WAIT_BUSY_HI: begin
        if (Busy) begin
          w_next_state = S_WAIT_BUSY_LO;
        end else if (w_busy_limit) begin
          w_next_state   = S_IDLE;
          w_timeout_fire = 1'b1;
        end
      end
      S_WAIT_BUSY_LO: begin
        if (!Busy) begin
          w_next_state = S_READ;
        end else if (w_busy_limit) begin
          w_next_state   = S_IDLE;
          w_timeout_fire = 1'b1;
        end
      end
      S_READ: begin
        rd_start     = 1'b1;
        w_next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (rd_done) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // r_cyc restarts on every state change, so it measures time spent in the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) r_cyc <= '0;
      else                         r_cyc <= r_cyc + CYC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enable_d     <= 1'b0;
      r_overrun      <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_burst_done   <= 1'b0;
      r_sample_count <= '0;
    end else begin
      r_enable_d <= enable;
      if (w_en_rise) begin
        r_overrun      <= 1'b0;
        r_timeout_err  <= 1'b0;
        r_burst_done   <= 1'b0;
        r_sample_count <= '0;
      end else begin
        if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
        if (w_timeout_fire)                r_timeout_err <= 1'b1;
        if (w_done_accept) begin
          r_sample_count <= w_count_inc;
          if ((burst_len != 16'd0) && (w_count_inc == {16'd0, burst_len}))
            r_burst_done <= 1'b1;
        end
      end
    end
  end

  assign overrun      = r_overrun;
  assign timeout_err  = r_timeout_err;
  assign burst_done   = r_burst_done;
  assign sample_count = r_sample_count;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Self-checking bench: table of period clamps, directed corner sequences, random windows vs. an event model.
module tb_adc_sample_scheduler;

  localparam int MIN_P = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] sample_period;
  logic [15:0] burst_len;
  logic        Busy;
  logic        rd_done;
  logic        convst_n;
  logic        rd_start;
  logic        sample_valid;
  logic        overrun;
  logic        timeout_err;
  logic        burst_done;
  logic [31:0] sample_count;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  adc_sample_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_period(sample_period),
    .burst_len    (burst_len),
    .Busy         (Busy),
    .rd_done      (rd_done),
    .convst_n     (convst_n),
    .rd_start     (rd_start),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .burst_done   (burst_done),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: Busy rises r_bd cycles after convst falls, stays r_bh cycles; rd_done r_rdl after rd_start.
  int   r_bd = 2, r_bh = 1, r_rdl = 1;
  bit   resp_on = 1'b1;
  logic man_busy = 1'b0, man_rd = 1'b0;
  int   t_on = -1, t_off = -1, t_done = -1;
  bit   prev_low = 1'b0;

  initial begin
    Busy    = 1'b0;
    rd_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!convst_n && !prev_low) begin
        t_on  = cyc + r_bd;
        t_off = cyc + r_bd + r_bh;
      end
      prev_low = !convst_n;
      if (rd_start) t_done = cyc + r_rdl;
      if (resp_on) begin
        Busy    = (cyc >= t_on) && (cyc < t_off);
        rd_done = (cyc == t_done);
      end else begin
        Busy    = man_busy;
        rd_done = man_rd;
      end
    end
  end

  int   n_rs = 0, n_sv = 0, n_cl = 0;
  int   fall_q[$];
  logic prev_cv = 1'b1;

  always @(negedge clk) begin
    if (rd_start === 1'b1)     n_rs <= n_rs + 1;
    if (sample_valid === 1'b1) n_sv <= n_sv + 1;
    if (convst_n === 1'b0)     n_cl <= n_cl + 1;
    if (convst_n === 1'b0 && prev_cv === 1'b1) fall_q.push_back(cyc);
    prev_cv <= convst_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d required end", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto_drive(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_chk(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  int win_c0, win_base;

  // Model: ticks at c0+k*P-1 inside the enable window; a tick within a conversion's
  // occupied span is an overrun, otherwise it starts a conversion unless the burst is complete.
  task automatic run_window(input int p, input int w, input int bl,
                            input int bd, input int bh, input int rdl);
    int pe, l, starts, busy_end, rs0, sv0, cl0;
    bit ovr, done;
    goto_drive(cyc + 1);
    sample_period = 16'(p);
    burst_len     = 16'(bl);
    r_bd = bd; r_bh = bh; r_rdl = rdl; resp_on = 1'b1;
    goto_drive(cyc + 1);
    rs0 = n_rs; sv0 = n_sv; cl0 = n_cl;
    win_base = fall_q.size();
    win_c0   = cyc;
    enable   = 1'b1;
    goto_chk(win_c0 + 1);
    chk("clr_count",   sample_count, 0);
    chk("clr_overrun", overrun, 0);
    chk("clr_timeout", timeout_err, 0);
    chk("clr_burst",   burst_done, 0);
    goto_drive(win_c0 + w);
    enable = 1'b0;

    pe = (p < MIN_P) ? MIN_P : p;
    l  = 2 + bd + bh + rdl;
    starts = 0; busy_end = -1; ovr = 0; done = 0;
    for (int x = pe - 1; x < w; x += pe) begin
      if (x <= busy_end) ovr = 1;
      else if (!done) begin
        starts++;
        busy_end = x + l;
        if (bl != 0 && starts == bl) done = 1;
      end
    end

    goto_chk(win_c0 + w + l + 5);
    chk("count",      sample_count, starts);
    chk("overrun",    overrun, 32'(ovr));
    chk("burst_done", burst_done, 32'(done));
    chk("timeout",    timeout_err, 0);
    chk("rd_starts",  n_rs - rs0, starts);
    chk("valids",     n_sv - sv0, starts);
    chk("convst_low", n_cl - cl0, 2 * starts);
  endtask

  typedef struct {
    int period;
    int eff;
  } per_vec_t;

  per_vec_t tbl[6];
  int c0, rs0;

  initial begin
    tbl[0] = '{0, 16};
    tbl[1] = '{4, 16};
    tbl[2] = '{15, 16};
    tbl[3] = '{16, 16};
    tbl[4] = '{17, 17};
    tbl[5] = '{100, 100};

    rst = 1'b0; enable = 1'b0; sample_period = 16'd100; burst_len = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_convst_n", convst_n, 1);
    chk("rst_rd_start", rd_start, 0);
    chk("rst_valid",    sample_valid, 0);
    chk("rst_overrun",  overrun, 0);
    chk("rst_timeout",  timeout_err, 0);
    chk("rst_burst",    burst_done, 0);
    chk("rst_count",    sample_count, 0);
    goto_drive(cyc + 1);
    rst = 1'b1;
    goto_drive(cyc + 3);

    for (int i = 0; i < 6; i++) begin
      run_window(tbl[i].period, 2 * tbl[i].eff + 3, 0, 2, 1, 1);
      chk("first_tick",   fall_q[win_base] - win_c0, tbl[i].eff);
      chk("tick_spacing", fall_q[win_base + 1] - fall_q[win_base], tbl[i].eff);
    end

    run_window(100, 500, 0, 20, 5, 10);
    chk("p100_spacing", fall_q[win_base + 4] - fall_q[win_base + 3], 100);

    // Busy never rises: timeout exactly 64 cycles into WAIT_BUSY_HI (entered at c0+102).
    goto_drive(cyc + 1);
    sample_period = 16'd100; burst_len = 16'd0;
    r_bd = 1_000_000; r_bh = 1; r_rdl = 1; resp_on = 1'b1;
    goto_drive(cyc + 1);
    c0 = cyc; rs0 = n_rs; enable = 1'b1;
    goto_chk(c0 + 165);
    chk("tmo_before", timeout_err, 0);
    goto_chk(c0 + 166);
    chk("tmo_at_64", timeout_err, 1);
    goto_chk(c0 + 200);
    chk("tmo_idle_restart", convst_n, 0);
    chk("tmo_no_overrun", overrun, 0);
    goto_drive(c0 + 201);
    enable = 1'b0;
    goto_chk(c0 + 280);
    chk("tmo_no_rd_start", n_rs - rs0, 0);

    run_window(20, 100, 0, 2, 3, 30);
    chk("ovr_restart_spacing", fall_q[win_base + 1] - fall_q[win_base], 40);

    run_window(16, 200, 3, 2, 2, 2);
    run_window(16, 200, 3, 2, 2, 2);

    for (int i = 0; i < 8; i++) begin
      run_window(int'($urandom_range(0, 60)), int'($urandom_range(20, 300)),
                 int'($urandom_range(0, 4)), int'($urandom_range(2, 30)),
                 int'($urandom_range(1, 30)), int'($urandom_range(1, 20)));
    end

    // Reset while parked in WAIT_BUSY_LO with nonzero count and overrun set.
    goto_drive(cyc + 1);
    sample_period = 16'd16; burst_len = 16'd0;
    r_bd = 2; r_bh = 1; r_rdl = 1; resp_on = 1'b1;
    goto_drive(cyc + 1);
    c0 = cyc; enable = 1'b1;
    goto_drive(c0 + 40);
    r_bh = 60;
    goto_chk(c0 + 66);
    chk("pre_rst_count",   sample_count, 2);
    chk("pre_rst_overrun", overrun, 1);
    goto_drive(c0 + 70);
    rst = 1'b0; enable = 1'b0;
    #2;
    chk("arst_convst_n", convst_n, 1);
    chk("arst_rd_start", rd_start, 0);
    chk("arst_valid",    sample_valid, 0);
    chk("arst_overrun",  overrun, 0);
    chk("arst_timeout",  timeout_err, 0);
    chk("arst_burst",    burst_done, 0);
    chk("arst_count",    sample_count, 0);
    goto_drive(c0 + 73);
    rst = 1'b1; resp_on = 1'b0; man_busy = 1'b0; man_rd = 1'b0;
    rs0 = n_rs;
    goto_drive(c0 + 75);
    man_rd = 1'b1;
    goto_chk(c0 + 75);
    chk("late_rd_valid", sample_valid, 0);
    goto_drive(c0 + 76);
    man_rd = 1'b0;
    goto_chk(c0 + 85);
    chk("late_rd_count", sample_count, 0);
    chk("post_rst_rd_start", n_rs - rs0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
